// File: rtl/mm_cmd_pkg.sv
// Shared types and constants for the Avalon-MM command master: FSM states,
// response status codes and fixed bus constants.
package mm_cmd_pkg;

    localparam int MM_DATA_W = 32;
    localparam int MM_BE_W   = 4;
    localparam logic [MM_BE_W-1:0] MM_BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OK          = 2'd0,
        TIMEOUT_REQ = 2'd1,
        TIMEOUT_RD  = 2'd2
    } rsp_status_t;

endpackage

// File: rtl/mm_timeout_ctr.sv
// Saturating phase counter for the command master; 'expired' is high while the
// count sits at TIMEOUT_CYCLES-1. Clear has priority over enable.
module mm_timeout_ctr
    import mm_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic mm_clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge mm_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_LAST);

endmodule

// File: rtl/mm_cmd_master.sv
// Avalon-MM master: one host command in, one single-beat transfer out, one response back.
// Define MM_CMD_MASTER_WRITE_ACK_EN to make writes (accepted or timed out) return a response.
module mm_cmd_master
    import mm_cmd_pkg::*;
#(
    parameter int ADDR_SIZE      = 4,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                   mm_clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_SIZE-1:0]   cmd_address,
    input  logic [MM_DATA_W-1:0]   cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [MM_DATA_W-1:0]   rsp_data,
    output rsp_status_t            rsp_status,
    output logic                   rsp_is_write,
    output logic [ADDR_SIZE-1:0]   mm_address,
    output logic                   mm_burstcount,
    output logic                   mm_read,
    output logic                   mm_write,
    output logic [MM_DATA_W-1:0]   mm_writedata,
    output logic [MM_BE_W-1:0]     mm_byteenable,
    input  logic                   mm_waitrequest,
    input  logic [MM_DATA_W-1:0]   mm_readdata,
    input  logic                   mm_readdatavalid
);

`ifdef MM_CMD_MASTER_WRITE_ACK_EN
    localparam bit WR_ACK_EN = 1'b1;
`else
    localparam bit WR_ACK_EN = 1'b0;
`endif

    state_t                 state_q,        state_d;
    logic                   cmd_ready_q,    cmd_ready_d;
    logic                   rsp_valid_q,    rsp_valid_d;
    logic [MM_DATA_W-1:0]   rsp_data_q,     rsp_data_d;
    rsp_status_t            rsp_status_q,   rsp_status_d;
    logic                   rsp_is_write_q, rsp_is_write_d;
    logic [ADDR_SIZE-1:0]   mm_address_q,   mm_address_d;
    logic                   mm_read_q,      mm_read_d;
    logic                   mm_write_q,     mm_write_d;
    logic [MM_DATA_W-1:0]   mm_writedata_q, mm_writedata_d;
    logic                   op_write_q,     op_write_d;

    logic ctr_clr;
    logic ctr_en;
    logic expired;

    // Every phase starts from zero; the counter only runs while waiting on the slave.
    assign ctr_clr = (state_d != state_q);
    assign ctr_en  = (state_q == REQ) || (state_q == RD_WAIT);

    mm_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .mm_clk  (mm_clk),
        .rst     (rst),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (expired)
    );

    always_comb begin
        state_d        = state_q;
        cmd_ready_d    = cmd_ready_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_data_d     = rsp_data_q;
        rsp_status_d   = rsp_status_q;
        rsp_is_write_d = rsp_is_write_q;
        mm_address_d   = mm_address_q;
        mm_read_d      = mm_read_q;
        mm_write_d     = mm_write_q;
        mm_writedata_d = mm_writedata_q;
        op_write_d     = op_write_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    mm_address_d   = cmd_address;
                    mm_writedata_d = cmd_wdata;
                    op_write_d     = cmd_write;
                    mm_read_d      = !cmd_write;
                    mm_write_d     = cmd_write;
                    cmd_ready_d    = 1'b0;
                    state_d        = REQ;
                end
            end

            REQ: begin
                if (!mm_waitrequest || expired) begin
                    mm_read_d  = 1'b0;
                    mm_write_d = 1'b0;
                    if (op_write_q && !WR_ACK_EN) begin
                        // Silent write: straight back to accepting commands.
                        cmd_ready_d = 1'b1;
                        state_d     = IDLE;
                    end else if (!mm_waitrequest && !op_write_q && !mm_readdatavalid) begin
                        state_d = RD_WAIT;
                    end else begin
                        rsp_valid_d    = 1'b1;
                        rsp_is_write_d = op_write_q;
                        rsp_data_d     = '0;
                        rsp_status_d   = mm_waitrequest ? TIMEOUT_REQ : OK;
                        if (!mm_waitrequest && !op_write_q) begin
                            rsp_data_d = mm_readdata;
                        end
                        state_d = RESP;
                    end
                end
            end

            RD_WAIT: begin
                if (mm_readdatavalid) begin
                    rsp_valid_d    = 1'b1;
                    rsp_is_write_d = 1'b0;
                    rsp_data_d     = mm_readdata;
                    rsp_status_d   = OK;
                    state_d        = RESP;
                end else if (expired) begin
                    rsp_valid_d    = 1'b1;
                    rsp_is_write_d = 1'b0;
                    rsp_data_d     = '0;
                    rsp_status_d   = TIMEOUT_RD;
                    state_d        = RESP;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge mm_clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cmd_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_status_q   <= OK;
            rsp_is_write_q <= 1'b0;
            mm_address_q   <= '0;
            mm_read_q      <= 1'b0;
            mm_write_q     <= 1'b0;
            mm_writedata_q <= '0;
            op_write_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_status_q   <= rsp_status_d;
            rsp_is_write_q <= rsp_is_write_d;
            mm_address_q   <= mm_address_d;
            mm_read_q      <= mm_read_d;
            mm_write_q     <= mm_write_d;
            mm_writedata_q <= mm_writedata_d;
            op_write_q     <= op_write_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_status    = rsp_status_q;
    assign rsp_is_write  = rsp_is_write_q;
    assign mm_address    = mm_address_q;
    assign mm_read       = mm_read_q;
    assign mm_write      = mm_write_q;
    assign mm_writedata  = mm_writedata_q;
    assign mm_burstcount = 1'b1;
    assign mm_byteenable = MM_BE_ALL;

endmodule
